// File: rtl/aha_tlx_training_tx.sv
// aha_tlx_training_tx
// TLX link training transmitter. On a START rising edge it latches a 32-bit
// training word and shifts it out on D_OUT LSB first, one bit per clock,
// repeating the word until LENGTH words are sent (AUTO_STOP=1) or a CLEAR
// rising edge aborts the run (AUTO_STOP=0 or any time). DONE is a sticky
// flag for a completed auto-stop run; SENT_COUNT counts complete words.
//
// Handshake: START and CLEAR are level inputs, sampled every cycle. Only a
// 0->1 transition is acted on. There is no backpressure: an accepted start
// edge begins transmission on the next cycle. CLEAR beats START when both
// rise together. Both are ignored while RESET is high.
//
// o_dbg_state exposes the FSM encoding (0=IDLE, 1=TRAINING, 2=FINISH) so
// that checkers can follow the run without probing internal signals.
module aha_tlx_training_tx (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        CLEAR,
  input  logic [31:0] SEQUENCE,
  input  logic [31:0] LENGTH,
  input  logic        AUTO_STOP,
  output logic        D_OUT,
  output logic        DONE,
  output logic        ACTIVE,
  output logic [31:0] SENT_COUNT,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAINING = 2'd1,
    FINISH   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_start_q;
  logic        r_clear_q;
  logic [31:0] r_seq;
  logic [31:0] r_len;
  logic        r_auto;
  logic [31:0] r_count;
  logic [4:0]  r_idx;
  logic        r_done;

  logic        w_start_pulse;
  logic        w_clear_pulse;
  logic        w_stop;
  logic        w_active;

  // Edge detection on the level inputs and the end-of-run condition.
  always_comb begin
    w_start_pulse = START & ~r_start_q;
    w_clear_pulse = CLEAR & ~r_clear_q;
    w_stop        = (r_state == TRAINING) & r_auto & (r_count == r_len);
    w_active      = (r_state == TRAINING) & ~w_stop;
  end

  // Control FSM with the bit index, word counter and latched run parameters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
      r_seq     <= 32'd0;
      r_len     <= 32'd0;
      r_auto    <= 1'b0;
      r_count   <= 32'd0;
      r_idx     <= 5'd0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= START;
      r_clear_q <= CLEAR;
      case (r_state)
        IDLE: begin
          r_idx <= 5'd0;
          if (w_start_pulse & ~w_clear_pulse) begin
            r_state <= TRAINING;
            r_seq   <= SEQUENCE;
            r_len   <= LENGTH;
            r_auto  <= AUTO_STOP;
            r_count <= 32'd0;
            r_done  <= 1'b0;
          end
        end
        TRAINING: begin
          if (w_clear_pulse) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
          end else if (w_stop) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_idx   <= 5'd0;
          end else begin
            // 5-bit index wraps 31 -> 0 on its own; a wrap closes a word.
            r_idx <= r_idx + 5'd1;
            if (r_idx == 5'd31) begin
              r_count <= r_count + 32'd1;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_idx   <= 5'd0;
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= 5'd0;
        end
      endcase
      // A clear edge always wipes the run result, whatever the state.
      if (w_clear_pulse) begin
        r_count <= 32'd0;
        r_done  <= 1'b0;
      end
    end
  end

  // Outputs are functions of registered state only; no input-to-output path.
  always_comb begin
    ACTIVE      = w_active;
    D_OUT       = w_active ? r_seq[r_idx] : 1'b0;
    DONE        = r_done;
    SENT_COUNT  = r_count;
    o_dbg_state = r_state;
  end

endmodule
